arb_req_ctrl: RTL
=================

// Module: arb_req_ctrl
// PURPOSE
//   Client-side controller for the fixed-priority arbiter: turns per-client start pulses
//   into held req lines, consumes grt, locks the granted client for a BURST_LEN-cycle
//   ownership window, then releases. While a client owns, only its own req bit is driven,
//   so a higher-priority client cannot steal the grant mid-burst. Also flags starvation
//   and grant-protocol errors.
// PARAMETERS
//   NCLI        5   number of clients (req/grt width)
//   BURST_LEN   4   cycles owner_vld stays high per grant (>=1)
//   STARVE_LIM  15  pending cycles after which starve[i] asserts (>=1)
// PORTS
//   clk       in   1     clock, all logic on rising edge
//   rst_      in   1     synchronous reset, active-HIGH
//   start     in   NCLI  per-client 1-cycle request pulse
//   grt       in   NCLI  grant vector from arbiter (combinational from req)
//   req       out  NCLI  request vector to arbiter
//   owner_vld out  1     a client currently owns the resource
//   owner_id  out  clog2(NCLI)  index of owner; 0 when owner_vld=0
//   done      out  NCLI  1-cycle pulse on owner's last ownership cycle
//   starve    out  NCLI  client i pending for STARVE_LIM+ cycles
//   err       out  1     sticky: grt[owner_id] low during ownership
// BEHAVIOUR
//   Reset: pend, owner_vld, owner_id, cnt, wait_cnt, err all 0 -> req, done, starve all 0.
//   Reset mid-burst aborts ownership: no done pulse, pending requests discarded.
//   State: pend[NCLI] regs; owner_vld/owner_id/cnt (down-counter, BURST_LEN-1..0);
//     wait_cnt[i] saturating, width clog2(STARVE_LIM+1).
//   Per-client states: IDLE(pend=0, not owner) -> PEND(pend=1) -> OWN -> IDLE.
//   start[i] accepted only in IDLE: sets pend[i] next cycle. Ignored while PEND or OWN,
//     incl. the owner's done cycle.
//   req = owner_vld ? onehot(owner_id) : pend (combinational from regs).
//   Capture: if !owner_vld and (grt & pend)!=0: owner_id <= lowest set bit of grt&pend,
//     owner_vld <= 1, cnt <= BURST_LEN-1, pend[owner] <= 0. grt ignored when pend=0.
//   Ownership: cnt decrements each owned cycle; when cnt==0, done[owner_id]=1 (comb)
//     and owner_vld <= 0, owner_id <= 0. Exactly BURST_LEN owned cycles.
//   Inter-burst gap: exactly one cycle with owner_vld=0 between back-to-back bursts.
//   Latency: start at t -> req at t+1 -> owner_vld at t+2 (with arbiter grant at t+1).
//   Starvation: wait_cnt[i] cleared while pend[i]=0; +1 each cycle pend[i]=1, saturate
//     at STARVE_LIM; starve[i] = pend[i] & (wait_cnt[i]==STARVE_LIM).
//   err: set when owner_vld & !grt[owner_id]; cleared only by reset; burst continues.
//   Simultaneous start[i] and capture: pend[i] was 0, so i is not capturable that cycle.
// TESTING (NCLI=5, BURST_LEN=4, STARVE_LIM=15; cycle 0 = first post-reset cycle)
//   start=00100 @0 -> req=00100 @1; owner_vld=1,id=2 @2-5; done[2] @5; req=0 @6.
//   start=10001 @0 -> id=0 @2-5 (req=00001), req=10000 @6, id=4 @7-10, done[4] @10.
//   start=11111 @0 -> owners 0,1,2,3,4 at @2,7,12,17,22; starve[3] @16 only;
//     starve[4] @16-21; err stays 0.
//   Scenario 1 with rst_=1 @3 -> all outputs 0 @4, no done pulse, req=0 after.
//   start[2] re-pulsed @3 and @5 during own -> ignored, single burst, req=0 @6.
//   Force grt=0 @3 while id=2 owns -> err=1 @4 onward; done[2] still @5.

Source files
------------

// File: rtl/arb_req_ctrl.sv
// ============================================================================
// Module : arb_req_ctrl
// Brief  : Client-side request/ownership controller for a fixed-priority arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arb_req_ctrl #(
  parameter int NCLI       = 5,
  parameter int BURST_LEN  = 4,
  parameter int STARVE_LIM = 15,
  localparam int IDW       = (NCLI > 1) ? $clog2(NCLI) : 1
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [NCLI-1:0] start,
  input  logic [NCLI-1:0] grt,
  output logic [NCLI-1:0] req,
  output logic            owner_vld,
  output logic [IDW-1:0]  owner_id,
  output logic [NCLI-1:0] done,
  output logic [NCLI-1:0] starve,
  output logic            err
);

  localparam int              CNTW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int              WW         = $clog2(STARVE_LIM + 1);
  localparam logic [CNTW-1:0] C_CNT_INIT = CNTW'(BURST_LEN - 1);
  localparam logic [WW-1:0]   C_WAIT_MAX = WW'(STARVE_LIM);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]      r_state, w_state_nxt;
  logic [IDW-1:0]  r_owner_id, w_owner_id_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;
  logic [NCLI-1:0] r_pend, w_pend_nxt;
  logic            r_err;

  logic [NCLI-1:0] w_cand;
  logic [NCLI-1:0] w_own_oh;
  logic [NCLI-1:0] w_cap_oh;
  logic [IDW-1:0]  w_cap_id;
  logic            w_capture;
  logic            w_last;
  logic            w_own_grt;

  // Grants to non-pending clients are meaningless and masked out here.
  assign w_cand    = grt & r_pend;
  assign w_capture = (r_state == ST_IDLE) && (|w_cand);
  assign w_last    = (r_state == ST_OWN) && (r_cnt == '0);
  assign w_own_grt = |(grt & w_own_oh);

  always_comb begin
    w_cap_id = '0;
    for (int i = NCLI - 1; i >= 0; i--) begin
      if (w_cand[i]) w_cap_id = IDW'(i);
    end
  end

  for (genvar i = 0; i < NCLI; i++) begin : g_oh
    assign w_own_oh[i] = (r_state == ST_OWN) && (r_owner_id == IDW'(i));
    assign w_cap_oh[i] = w_capture && (w_cap_id == IDW'(i));
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state    <= ST_IDLE;
      r_owner_id <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner_id <= w_owner_id_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_id_nxt = r_owner_id;
    w_cnt_nxt      = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_capture) begin
          w_state_nxt    = ST_OWN;
          w_owner_id_nxt = w_cap_id;
          w_cnt_nxt      = C_CNT_INIT;
        end
      end
      ST_OWN: begin
        if (r_cnt == '0) begin
          w_state_nxt    = ST_IDLE;
          w_owner_id_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNTW'(1);
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_owner_id_nxt = '0;
        w_cnt_nxt      = '0;
      end
    endcase
  end

  always_comb begin
    owner_vld = (r_state == ST_OWN);
    owner_id  = r_owner_id;
    req       = owner_vld ? w_own_oh : r_pend;
    done      = w_last ? w_own_oh : '0;
    err       = r_err;
  end

  // A start is only honoured by a client that is neither pending nor owning.
  assign w_pend_nxt = (r_pend & ~w_cap_oh) | (start & ~r_pend & ~w_own_oh);

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_pend <= '0;
      r_err  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if ((r_state == ST_OWN) && !w_own_grt) r_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NCLI; i++) begin : g_cli
    logic [WW-1:0] r_wait;

    always_ff @(posedge clk) begin
      if (rst_ || !r_pend[i]) begin
        r_wait <= '0;
      end else if (r_wait != C_WAIT_MAX) begin
        r_wait <= r_wait + WW'(1);
      end
    end

    assign starve[i] = r_pend[i] && (r_wait == C_WAIT_MAX);
  end

endmodule

`default_nettype wire
